// File: rtl/l2_pkg.sv
// Shared types and helpers for the L2 cache control path:
// FSM state enum, cache-op mode codes, one-hot to index encoder.
package l2_pkg;

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_LOOKUP       = 4'd1,
        S_CHECK_DIRTY  = 4'd2,
        S_WRITEBACK    = 4'd3,
        S_REFILL_REQ   = 4'd4,
        S_REFILL_WAIT  = 4'd5,
        S_REFILL_WRITE = 4'd6,
        S_UC_WRITE     = 4'd7,
        S_CACOP        = 4'd8
    } l2_state_e;

    localparam logic [1:0] CACOP_INIT      = 2'd0;
    localparam logic [1:0] CACOP_IDX_WBINV = 2'd1;
    localparam logic [1:0] CACOP_HIT_WBINV = 2'd2;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [3:0] onehot_lsb_enc(input logic [15:0] v);
        logic [3:0] enc;
        enc = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) enc = 4'(i);
        end
        return enc;
    endfunction

endpackage

// File: rtl/l2_rr_arbiter.sv
// Round-robin arbiter over NUM_REQ requesters.
// Ports: clk/rstn, valid_i, en_i -> gnt_o (one-hot), gnt_id_o, gnt_vld_o.
module l2_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [REQ_W-1:0]   gnt_id_o,
    output logic               gnt_vld_o
);

    logic [REQ_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int k;
        k         = 0;
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr_q) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (en_i && !gnt_vld_o && valid_i[REQ_W'(k)]) begin
                gnt_vld_o = 1'b1;
                gnt_id_o  = REQ_W'(k);
            end
        end
        gnt_o = gnt_vld_o ? (NUM_REQ'(1) << gnt_id_o) : '0;
        ptr_d = (gnt_id_o == REQ_W'(NUM_REQ - 1)) ? '0 : gnt_id_o + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          ptr_q <= '0;
        else if (gnt_vld_o) ptr_q <= ptr_d;
    end

endmodule

// File: rtl/l2cache_ctrl_fsm.sv
// Main control FSM of the write-back/write-allocate L2 cache.
// Ports: requester handshakes, request-buffer view, cacop, way controls, memory handshake.
module l2cache_ctrl_fsm
    import l2_pkg::*;
#(
    parameter  int WAYS    = 4,
    parameter  int NUM_REQ = 2,
    localparam int WAY_W   = $clog2(WAYS),
    localparam int REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_write,
    input  logic [NUM_REQ-1:0] req_uc,
    output logic [NUM_REQ-1:0] req_addr_ok,
    output logic [NUM_REQ-1:0] req_data_ok,
    output logic               rbuf_we,
    output logic [REQ_W-1:0]   rbuf_id,
    input  logic [REQ_W-1:0]   cur_id,
    input  logic               cur_write,
    input  logic               cur_uc,
    input  logic               cacop_valid,
    input  logic [1:0]         cacop_mode,
    input  logic [WAY_W-1:0]   cacop_way,
    output logic               cacop_ready,
    input  logic [WAYS-1:0]    hit,
    input  logic [WAY_W-1:0]   victim,
    input  logic               dirty,
    output logic [WAYS-1:0]    data_we,
    output logic               data_replace,
    output logic               data_wb,
    output logic [WAYS-1:0]    tagv_inv,
    output logic               tagv_init,
    output logic [WAY_W-1:0]   tagv_way,
    output logic [WAY_W-1:0]   choose_way,
    output logic [WAY_W-1:0]   dirty_way,
    output logic               dirty_set,
    output logic               dirty_clr,
    output logic [WAYS-1:0]    plru_use,
    output logic               choose_return,
    output logic               mem_req_r,
    output logic               mem_req_w,
    output logic               mem_rdy,
    input  logic               mem_addr_ok_r,
    input  logic               mem_addr_ok_w,
    input  logic               mem_data_ok
);

    l2_state_e          state_q, state_d;
    logic [WAY_W-1:0]   lway_q, lway_d;
    logic               cacop_q, cacop_d;
    logic [WAY_W-1:0]   hway;
    logic               hit_any, lk_hit, arb_en, gnt_vld, fill;
    logic [NUM_REQ-1:0] gnt, cur_oh;
    logic [REQ_W-1:0]   gnt_id;
    logic [WAYS-1:0]    wl, wh, wc;

    assign hway    = WAY_W'(onehot_lsb_enc(16'(hit)));
    assign hit_any = |hit;
    assign lk_hit  = (state_q == S_LOOKUP) && !cur_uc && hit_any;
    // Gating with rstn keeps every output low while reset is held.
    assign arb_en  = rstn &&
                     (((state_q == S_IDLE) && !cacop_valid) || lk_hit);
    assign wl      = WAYS'(1) << lway_q;
    assign wh      = WAYS'(1) << hway;
    assign wc      = WAYS'(1) << cacop_way;
    assign cur_oh  = NUM_REQ'(1) << cur_id;

    l2_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .valid_i   (req_valid),
        .en_i      (arb_en),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_vld_o (gnt_vld)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            lway_q  <= '0;
            cacop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lway_q  <= lway_d;
            cacop_q <= cacop_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        lway_d        = lway_q;
        cacop_d       = cacop_q;
        fill          = 1'b0;
        req_addr_ok   = '0;
        req_data_ok   = '0;
        rbuf_we       = 1'b0;
        rbuf_id       = '0;
        cacop_ready   = 1'b0;
        data_we       = '0;
        data_replace  = 1'b0;
        data_wb       = 1'b0;
        tagv_inv      = '0;
        tagv_init     = 1'b0;
        tagv_way      = '0;
        choose_way    = '0;
        dirty_way     = '0;
        dirty_set     = 1'b0;
        dirty_clr     = 1'b0;
        plru_use      = '0;
        choose_return = 1'b0;
        mem_req_r     = 1'b0;
        mem_req_w     = 1'b0;
        mem_rdy       = 1'b0;

        // Uncached writes are acknowledged only once memory takes them.
        if (gnt_vld) begin
            req_addr_ok = gnt & ~(req_uc & req_write);
            rbuf_we     = 1'b1;
            rbuf_id     = gnt_id;
        end

        unique case (state_q)
            S_IDLE: begin
                if (rstn && cacop_valid) begin
                    cacop_ready = 1'b1;
                    rbuf_we     = 1'b1;
                    cacop_d     = 1'b1;
                    state_d     = S_CACOP;
                end else if (gnt_vld) begin
                    cacop_d = 1'b0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (cur_uc) begin
                    state_d = cur_write ? S_UC_WRITE : S_REFILL_REQ;
                end else if (hit_any) begin
                    choose_way = hway;
                    plru_use   = wh;
                    if (cur_write) begin
                        data_we   = wh;
                        dirty_set = 1'b1;
                        dirty_way = hway;
                    end else begin
                        req_data_ok = cur_oh;
                    end
                    state_d = gnt_vld ? S_LOOKUP : S_IDLE;
                end else begin
                    lway_d  = victim;
                    state_d = S_CHECK_DIRTY;
                end
            end
            S_CHECK_DIRTY: begin
                dirty_way  = lway_q;
                choose_way = lway_q;
                tagv_way   = lway_q;
                if (dirty) begin
                    data_wb = 1'b1;
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = cacop_q ? S_IDLE : S_REFILL_REQ;
                end
            end
            S_WRITEBACK: begin
                mem_req_w  = 1'b1;
                data_wb    = 1'b1;
                choose_way = lway_q;
                tagv_way   = lway_q;
                dirty_way  = lway_q;
                if (mem_addr_ok_w)
                    state_d = cacop_q ? S_IDLE : S_REFILL_REQ;
            end
            S_REFILL_REQ: begin
                mem_req_r = 1'b1;
                if (mem_addr_ok_r) begin
                    state_d = S_REFILL_WAIT;
                    fill    = mem_data_ok;
                end
            end
            S_REFILL_WAIT: begin
                mem_rdy = 1'b1;
                fill    = mem_data_ok;
            end
            S_REFILL_WRITE: begin
                data_we    = wl;
                dirty_set  = 1'b1;
                dirty_way  = lway_q;
                choose_way = lway_q;
                plru_use   = wl;
                state_d    = S_IDLE;
            end
            S_UC_WRITE: begin
                mem_req_w = 1'b1;
                if (mem_addr_ok_w) begin
                    req_addr_ok = cur_oh;
                    req_data_ok = cur_oh;
                    state_d     = S_IDLE;
                end
            end
            S_CACOP: begin
                case (cacop_mode)
                    CACOP_INIT: begin
                        tagv_init = 1'b1;
                        tagv_way  = cacop_way;
                        state_d   = S_IDLE;
                    end
                    CACOP_IDX_WBINV: begin
                        tagv_inv = wc;
                        tagv_way = cacop_way;
                        lway_d   = cacop_way;
                        state_d  = S_CHECK_DIRTY;
                    end
                    CACOP_HIT_WBINV: begin
                        if (hit_any) begin
                            tagv_inv = wh;
                            tagv_way = hway;
                            lway_d   = hway;
                            state_d  = S_CHECK_DIRTY;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            default: state_d = S_IDLE;
        endcase

        // Refill data arrival, reachable from REFILL_REQ or REFILL_WAIT.
        if (fill) begin
            choose_return = 1'b1;
            if (!cur_uc) begin
                data_replace = 1'b1;
                data_we      = wl;
                dirty_clr    = 1'b1;
                dirty_way    = lway_q;
                choose_way   = lway_q;
                tagv_way     = lway_q;
            end
            if (cur_uc || !cur_write) begin
                req_data_ok = cur_oh;
                if (!cur_uc) plru_use = wl;
                state_d = S_IDLE;
            end else begin
                state_d = S_REFILL_WRITE;
            end
        end
    end

endmodule
